// File: rtl/fp_apu_arbiter.sv
// fp_apu_arbiter: two-requester arbiter in front of a shared FPU, with an in-order response ID FIFO.
// Define FP_ARB_STATS_EN to add saturating per-requester issue counters on issue_cnt_o.
module fp_apu_arbiter #(
    parameter int DEPTH            = 4,
    parameter int CNT_W            = 16,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [1:0]                           req_i,
    output logic [1:0]                           gnt_o,
    input  logic [1:0][APU_NARGS_CPU-1:0][31:0]  operands_i,
    input  logic [1:0][APU_WOP_CPU-1:0]          op_i,
    input  logic [1:0][APU_NDSFLAGS_CPU-5:0]     flags_i,
    output logic [1:0]                           rvalid_o,
    output logic [31:0]                          rdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]          rflags_o,
    output logic                                 apu_req_o,
    output logic [APU_NARGS_CPU-1:0][31:0]       apu_operands_o,
    output logic [APU_WOP_CPU-1:0]               apu_op_o,
    output logic [APU_NDSFLAGS_CPU-5:0]          apu_flags_o,
    input  logic                                 apu_gnt_i,
    input  logic                                 apu_rvalid_i,
    input  logic [31:0]                          apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]          apu_rflags_i,
    output logic                                 err_o
`ifdef FP_ARB_STATS_EN
    ,
    output logic [1:0][CNT_W-1:0]                issue_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           r_state, w_next;
    logic             r_sel, r_last, r_err;
    logic             w_sel, w_push, w_pop;
    logic [DEPTH-1:0] r_fifo;
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;

    // HOLD freezes the selection so the FPU sees a stable request until it grants
    always_comb begin
        w_sel     = (r_state == HOLD) ? r_sel : ((&req_i) ? ~r_last : req_i[1]);
        apu_req_o = !rst_i && (|req_i) && (r_count != FULL);
        w_push    = apu_req_o && apu_gnt_i;
        w_pop     = apu_rvalid_i && (r_count != '0);
        gnt_o     = {w_push && w_sel, w_push && !w_sel};
        rvalid_o  = w_pop ? {r_fifo[r_rptr], !r_fifo[r_rptr]} : 2'b00;
        w_next    = w_push ? IDLE :
                    (r_state == IDLE) ? (apu_req_o ? HOLD : IDLE) :
                    (req_i[r_sel] ? HOLD : IDLE);
    end

    assign apu_operands_o = operands_i[w_sel];
    assign apu_op_o       = op_i[w_sel];
    assign apu_flags_o    = flags_i[w_sel];
    assign rdata_o        = apu_rdata_i;
    assign rflags_o       = apu_rflags_i;
    assign err_o          = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel;
            if (w_push) r_last <= w_sel;
            r_err   <= r_err | (apu_rvalid_i && (r_count == '0));
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_fifo[r_wptr] <= w_sel;
    end

`ifdef FP_ARB_STATS_EN
    logic [1:0][CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_cnt <= '0;
        else for (int k = 0; k < 2; k++) if (gnt_o[k] && !(&r_cnt[k])) r_cnt[k] <= r_cnt[k] + CNT_W'(1);
    end

    assign issue_cnt_o = r_cnt;
`endif
endmodule

// File: tb/tb_fp_apu_arbiter.sv
// tb_fp_apu_arbiter: directed and random checks of fp_apu_arbiter against a queue-based reference model.
module tb_fp_apu_arbiter;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [1:0]        req_i = '0;
    logic [1:0]        gnt_o;
    logic [1:0][2:0][31:0] operands_i;
    logic [1:0][5:0]   op_i;
    logic [1:0][10:0]  flags_i;
    logic [1:0]        rvalid_o;
    logic [31:0]       rdata_o;
    logic [4:0]        rflags_o;
    logic              apu_req_o;
    logic [2:0][31:0]  apu_operands_o;
    logic [5:0]        apu_op_o;
    logic [10:0]       apu_flags_o;
    logic              apu_gnt_i = 1'b0;
    logic              apu_rvalid_i = 1'b0;
    logic [31:0]       apu_rdata_i = '0;
    logic [4:0]        apu_rflags_i = '0;
    logic              err_o;
`ifdef FP_ARB_STATS_EN
    logic [1:0][CNT_W-1:0] issue_cnt_o;
    int m_cnt[2];
`endif

    fp_apu_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .operands_i(operands_i), .op_i(op_i), .flags_i(flags_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rflags_o(rflags_o),
        .apu_req_o(apu_req_o), .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o),
        .apu_flags_o(apu_flags_o), .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i),
        .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i), .err_o(err_o)
`ifdef FP_ARB_STATS_EN
        , .issue_cnt_o(issue_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nfail = 0;
    bit rnd_data = 1'b0;
    // reference model: outstanding IDs in issue order, last winner, and a held selection
    int m_q[$];
    int m_last, m_psel;
    bit m_hold, m_err;
    logic [1:0] o_gnt, o_rv;
    logic o_req;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 3; a++) operands_i[k][a] = $urandom;
            op_i[k] = 6'($urandom);
            flags_i[k] = 11'($urandom);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last = 1;
        m_psel = 0;
        m_hold = 1'b0;
        m_err = 1'b0;
`ifdef FP_ARB_STATS_EN
        m_cnt[0] = 0;
        m_cnt[1] = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = 2'b11;
        apu_gnt_i = 1'b1;
        apu_rvalid_i = 1'b1;
        #1;
        chk("rst_gnt", 128'(gnt_o), 128'(2'b00));
        chk("rst_rvalid", 128'(rvalid_o), 128'(2'b00));
        chk("rst_apu_req", 128'(apu_req_o), 128'(1'b0));
        chk("rst_err", 128'(err_o), 128'(1'b0));
`ifdef FP_ARB_STATS_EN
        chk("rst_cnt", 128'(issue_cnt_o), 128'(0));
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        req_i = 2'b00;
        apu_gnt_i = 1'b0;
        apu_rvalid_i = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [1:0] r, input logic g, input logic rv);
        int sel;
        bit ereq, epop;
        logic [1:0] eg, erv;
        @(negedge clk_i);
        req_i = r;
        apu_gnt_i = g;
        apu_rvalid_i = rv;
        if (rnd_data) randomize_data();
        apu_rdata_i = $urandom;
        apu_rflags_i = 5'($urandom);
        #1;
        sel = m_hold ? m_psel : (r == 2'b11 ? 1 - m_last : int'(r[1]));
        ereq = (r != 2'b00) && (m_q.size() < DEPTH);
        eg = (ereq && g) ? 2'(1 << sel) : 2'b00;
        epop = rv && (m_q.size() > 0);
        erv = epop ? 2'(1 << m_q[0]) : 2'b00;
        o_gnt = gnt_o;
        o_rv = rvalid_o;
        o_req = apu_req_o;
        chk("gnt", 128'(gnt_o), 128'(eg));
        chk("apu_req", 128'(apu_req_o), 128'(ereq));
        chk("rvalid", 128'(rvalid_o), 128'(erv));
        chk("err", 128'(err_o), 128'(m_err));
        chk("apu_op", 128'(apu_op_o), 128'(op_i[sel]));
        chk("apu_operands", 128'(apu_operands_o), 128'(operands_i[sel]));
        chk("apu_flags", 128'(apu_flags_o), 128'(flags_i[sel]));
        if (epop) begin
            chk("rdata", 128'(rdata_o), 128'(apu_rdata_i));
            chk("rflags", 128'(rflags_o), 128'(apu_rflags_i));
        end
`ifdef FP_ARB_STATS_EN
        chk("cnt0", 128'(issue_cnt_o[0]), 128'(m_cnt[0]));
        chk("cnt1", 128'(issue_cnt_o[1]), 128'(m_cnt[1]));
`endif
        if (rv && m_q.size() == 0) m_err = 1'b1;
        if (epop) void'(m_q.pop_front());
        if (eg != 2'b00) begin
            m_q.push_back(sel);
            m_last = sel;
            m_hold = 1'b0;
`ifdef FP_ARB_STATS_EN
            if (m_cnt[sel] < (1 << CNT_W) - 1) m_cnt[sel]++;
`endif
        end else if (m_hold) begin
            m_hold = r[m_psel];
        end else if (ereq) begin
            m_hold = 1'b1;
            m_psel = sel;
        end
    endtask

    initial begin
        op_i = {6'h2A, 6'h15};
        flags_i = {11'h5A5, 11'h0F0};
        operands_i = {96'hAAAA_0001_AAAA_0002_AAAA_0003, 96'h5555_0001_5555_0002_5555_0003};
        model_reset();
        do_reset();

        // single requester, zero-latency grant, response three cycles later
        step(2'b01, 1'b1, 1'b0);
        chk("t31_gnt", 128'(o_gnt), 128'(2'b01));
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        chk("t31_rvalid", 128'(o_rv), 128'(2'b01));

        // contention alternates starting with requester 0
        do_reset();
        step(2'b11, 1'b1, 1'b0);
        chk("t32_g0", 128'(o_gnt), 128'(2'b01));
        step(2'b11, 1'b1, 1'b0);
        chk("t32_g1", 128'(o_gnt), 128'(2'b10));
        step(2'b11, 1'b1, 1'b0);
        chk("t32_g2", 128'(o_gnt), 128'(2'b01));
        step(2'b11, 1'b1, 1'b0);
        chk("t32_g3", 128'(o_gnt), 128'(2'b10));
        for (int i = 0; i < 4; i++) step(2'b00, 1'b0, 1'b1);

        // backpressure keeps requester 1 selected while requester 0 rises
        do_reset();
        step(2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b0, 1'b0);
            chk("t33_op_held", 128'(apu_op_o), 128'(6'h2A));
        end
        step(2'b11, 1'b1, 1'b0);
        chk("t33_first", 128'(o_gnt), 128'(2'b10));
        step(2'b11, 1'b1, 1'b0);
        chk("t33_second", 128'(o_gnt), 128'(2'b01));
        step(2'b00, 1'b0, 1'b1);
        chk("t33_rv0", 128'(o_rv), 128'(2'b10));
        step(2'b00, 1'b0, 1'b1);
        chk("t33_rv1", 128'(o_rv), 128'(2'b01));

        // full FIFO blocks the request; a pop frees it only on the next cycle
        do_reset();
        for (int i = 0; i < 4; i++) step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        chk("t34_full_req", 128'(o_req), 128'(1'b0));
        chk("t34_full_gnt", 128'(o_gnt), 128'(2'b00));
        step(2'b01, 1'b1, 1'b1);
        chk("t34_pop_req", 128'(o_req), 128'(1'b0));
        step(2'b01, 1'b1, 1'b0);
        chk("t34_after_req", 128'(o_req), 128'(1'b1));

        // reset drops outstanding IDs, so the next response is spurious
        do_reset();
        step(2'b00, 1'b0, 1'b1);
        chk("t35_rvalid", 128'(o_rv), 128'(2'b00));
        step(2'b00, 1'b0, 1'b0);
        chk("t35_err", 128'(err_o), 128'(1'b1));
        step(2'b00, 1'b0, 1'b0);
        chk("t35_err_held", 128'(err_o), 128'(1'b1));

        // requester drops in HOLD: no push happens
        do_reset();
        step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        chk("t26_gnt", 128'(o_gnt), 128'(2'b10));
        step(2'b00, 1'b0, 1'b1);
        chk("t26_rv", 128'(o_rv), 128'(2'b10));
        step(2'b00, 1'b0, 1'b1);
        chk("t26_empty", 128'(o_rv), 128'(2'b00));

        // random traffic
        do_reset();
        rnd_data = 1'b1;
        for (int i = 0; i < 400; i++)
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
        rnd_data = 1'b0;

`ifdef FP_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 20; i++) step(2'b01, 1'b1, m_q.size() > 0);
        @(negedge clk_i);
        #1;
        chk("t36_cnt0", 128'(issue_cnt_o[0]), 128'(15));
        chk("t36_cnt1", 128'(issue_cnt_o[1]), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
